// File: rtl/overlay_effect_scheduler.sv
// Frame-synchronous overlay scheduler: grants one key requester and runs a fade-in/hold/fade-out blend envelope.
// Build option: OVERLAY_SCHED_FIXED_PRIO_EN selects fixed lowest-index priority instead of round-robin.
module overlay_effect_scheduler #(
   parameter int NUM_REQ     = 8,
   parameter int HOLD_FRAMES = 30,
   parameter int FADE_STEP   = 1,
   parameter int MAX_LEVEL   = 15,
   localparam int SEL_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               vsync,
   input  logic [NUM_REQ-1:0] req,
   output logic [SEL_W-1:0]   effect_sel,
   output logic               effect_valid,
   output logic [3:0]         level,
   output logic [NUM_REQ-1:0] grant,
   output logic [1:0]         state_o
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      FADE_IN  = 2'd1,
      HOLD     = 2'd2,
      FADE_OUT = 2'd3
   } state_t;

   localparam int              HC_W      = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
   localparam logic [HC_W-1:0] HC_LAST   = HC_W'(HOLD_FRAMES - 1);
   localparam logic [4:0]      STEP5     = 5'(FADE_STEP);
   localparam logic [4:0]      MAX5      = 5'(MAX_LEVEL);
   localparam logic [3:0]      MAX4      = 4'(MAX_LEVEL);
   localparam logic [3:0]      FIRST_LVL = (FADE_STEP >= MAX_LEVEL) ? MAX4 : 4'(FADE_STEP);

   state_t            state_q, state_d;
   logic [3:0]        level_q, level_d;
   logic [SEL_W-1:0]  sel_q, sel_d;
   logic [SEL_W-1:0]  last_q, last_d;
   logic [HC_W-1:0]   hold_cnt_q, hold_cnt_d;
   logic              vsync_q;
   logic              frame_done;

   logic              win_found;
   logic [SEL_W-1:0]  win_idx;
   logic [4:0]        lvl_up;
   logic [3:0]        lvl_up_sat;
   logic [3:0]        lvl_dn;
   logic              own_req;
   logic              other_req;

   assign frame_done = vsync_q & ~vsync;

`ifdef OVERLAY_SCHED_FIXED_PRIO_EN
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (req[i] && !win_found) begin
            win_found = 1'b1;
            win_idx   = SEL_W'(i);
         end
      end
   end
`else
   // Distance from the slot after last_q; the set bit with the smallest distance wins.
   always_comb begin
      int best_d;
      int d;
      win_found = 1'b0;
      win_idx   = '0;
      best_d    = NUM_REQ;
      d         = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (req[i]) begin
            d = (i + NUM_REQ - 1 - int'(last_q)) % NUM_REQ;
            if (d < best_d) begin
               best_d    = d;
               win_found = 1'b1;
               win_idx   = SEL_W'(i);
            end
         end
      end
   end
`endif

   always_comb begin
      grant = '0;
      for (int i = 0; i < NUM_REQ; i++)
         grant[i] = (state_q != IDLE) && (sel_q == SEL_W'(i));
   end

   assign lvl_up     = {1'b0, level_q} + STEP5;
   assign lvl_up_sat = (lvl_up >= MAX5) ? MAX4 : lvl_up[3:0];
   assign lvl_dn     = ({1'b0, level_q} <= STEP5) ? 4'd0 : (level_q - STEP5[3:0]);
   assign own_req    = |(req & grant);
   assign other_req  = |(req & ~grant);

   always_comb begin
      state_d    = state_q;
      level_d    = level_q;
      sel_d      = sel_q;
      last_d     = last_q;
      hold_cnt_d = hold_cnt_q;
      if (frame_done) begin
         case (state_q)
            IDLE: begin
               if (win_found) begin
                  sel_d   = win_idx;
                  last_d  = win_idx;
                  level_d = FIRST_LVL;
                  if (FIRST_LVL == MAX4) begin
                     state_d    = HOLD;
                     hold_cnt_d = '0;
                  end else begin
                     state_d = FADE_IN;
                  end
               end
            end
            FADE_IN: begin
               level_d = lvl_up_sat;
               if (lvl_up_sat == MAX4) begin
                  state_d    = HOLD;
                  hold_cnt_d = '0;
               end
            end
            HOLD: begin
               if (hold_cnt_q == HC_LAST && (!own_req || other_req)) begin
                  level_d = lvl_dn;
                  state_d = (lvl_dn == 4'd0) ? IDLE : FADE_OUT;
               end else if (hold_cnt_q != HC_LAST) begin
                  hold_cnt_d = hold_cnt_q + HC_W'(1);
               end
            end
            FADE_OUT: begin
               level_d = lvl_dn;
               if (lvl_dn == 4'd0) state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         vsync_q    <= 1'b0;
         state_q    <= IDLE;
         level_q    <= 4'd0;
         sel_q      <= '0;
         last_q     <= SEL_W'(NUM_REQ - 1);
         hold_cnt_q <= '0;
      end else begin
         vsync_q    <= vsync;
         state_q    <= state_d;
         level_q    <= level_d;
         sel_q      <= sel_d;
         last_q     <= last_d;
         hold_cnt_q <= hold_cnt_d;
      end
   end

   assign effect_sel   = sel_q;
   assign effect_valid = (state_q != IDLE);
   assign level        = level_q;
   assign state_o      = state_q;

endmodule

// File: tb/tb_overlay_effect_scheduler.sv
// Bench for overlay_effect_scheduler: directed frame sequences plus random requests against a frame-level model.
module tb_overlay_effect_scheduler;
   localparam int N = 4, HF = 2, STEP = 5, MAXL = 15;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         vsync = 1'b0;
   logic [N-1:0] req = '0;
   logic [1:0]   effect_sel;
   logic         effect_valid;
   logic [3:0]   level;
   logic [N-1:0] grant;
   logic [1:0]   state_o;

   int checks = 0;
   int errors = 0;

   // frame-level reference: phase 0 idle, 1 rising, 2 full, 3 falling
   int m_phase, m_lvl, m_sel, m_last, m_hc;

   overlay_effect_scheduler #(.NUM_REQ(N), .HOLD_FRAMES(HF), .FADE_STEP(STEP), .MAX_LEVEL(MAXL)) dut (
      .clk(clk), .reset(reset), .vsync(vsync), .req(req),
      .effect_sel(effect_sel), .effect_valid(effect_valid), .level(level),
      .grant(grant), .state_o(state_o));

   always #5 clk = ~clk;

   task automatic m_reset();
      m_phase = 0; m_lvl = 0; m_sel = 0; m_last = N - 1; m_hc = 0;
   endtask

   function automatic int pick(logic [N-1:0] rq);
`ifdef OVERLAY_SCHED_FIXED_PRIO_EN
      for (int i = 0; i < N; i++) if (rq[i]) return i;
`else
      for (int k = 1; k <= N; k++) if (rq[(m_last + k) % N]) return (m_last + k) % N;
`endif
      return -1;
   endfunction

   task automatic m_frame(logic [N-1:0] rq);
      int w;
      logic [N-1:0] own;
      own = '0;
      own[m_sel] = 1'b1;
      case (m_phase)
         0: begin
            w = pick(rq);
            if (w >= 0) begin
               m_sel = w; m_last = w;
               m_lvl = (STEP < MAXL) ? STEP : MAXL;
               if (m_lvl == MAXL) begin m_phase = 2; m_hc = 0; end
               else m_phase = 1;
            end
         end
         1: begin
            m_lvl = m_lvl + STEP;
            if (m_lvl >= MAXL) begin m_lvl = MAXL; m_phase = 2; m_hc = 0; end
         end
         2: begin
            if (m_hc == HF - 1 && ((rq & own) == 0 || (rq & ~own) != 0)) begin
               m_lvl = (m_lvl > STEP) ? m_lvl - STEP : 0;
               m_phase = (m_lvl == 0) ? 0 : 3;
            end else if (m_hc < HF - 1) begin
               m_hc++;
            end
         end
         default: begin
            m_lvl = (m_lvl > STEP) ? m_lvl - STEP : 0;
            if (m_lvl == 0) m_phase = 0;
         end
      endcase
   endtask

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_all(string tag);
      logic [N-1:0] g;
      g = '0;
      if (m_phase != 0) g[m_sel] = 1'b1;
      chk({tag, ".level"}, 32'(level), 32'(m_lvl));
      chk({tag, ".valid"}, 32'(effect_valid), 32'(m_phase != 0));
      chk({tag, ".sel"},   32'(effect_sel), 32'(m_sel));
      chk({tag, ".grant"}, 32'(grant), 32'(g));
      chk({tag, ".state"}, 32'(state_o), 32'(m_phase));
   endtask

   // One frame: vsync high with noise on req, then the falling edge samples val.
   task automatic frame(string tag, logic [N-1:0] val);
      @(negedge clk);
      vsync = 1'b1;
      req = N'($urandom);
      repeat ($urandom_range(1, 4)) begin
         @(negedge clk);
         req = N'($urandom);
         check_all({tag, ".pre"});
      end
      @(negedge clk);
      vsync = 1'b0;
      req = val;
      @(posedge clk);
      if (reset) m_reset(); else m_frame(val);
      @(negedge clk);
      check_all(tag);
      req = N'($urandom);
      repeat ($urandom_range(1, 3)) begin
         @(negedge clk);
         check_all({tag, ".post"});
      end
   endtask

   task automatic drain();
      int guard;
      guard = 0;
      while (m_phase != 0 && guard < 20) begin
         frame("drain", '0);
         guard++;
      end
      chk("drain_idle", 32'(state_o), 32'd0);
   endtask

   initial begin
      logic [N-1:0] rq;
      m_reset();
      // reset with vsync toggling
      repeat (3) frame("rst", N'($urandom));
      @(negedge clk);
      reset = 1'b0;

      // single key ramp up
      frame("t2f1", 4'b0100);
      chk("t2f1_lvl", 32'(level), 32'd5);
      chk("t2f1_grant", 32'(grant), 32'b0100);
      frame("t2f2", 4'b0100);
      frame("t2f3", 4'b0100);
      chk("t2f3_lvl", 32'(level), 32'd15);
      chk("t2f3_state", 32'(state_o), 32'd2);

      // release, hold minimum, fade out
      frame("t3f4", 4'b0000);
      chk("t3f4_state", 32'(state_o), 32'd2);
      frame("t3f5", 4'b0000);
      chk("t3f5_lvl", 32'(level), 32'd10);
      frame("t3f6", 4'b0000);
      frame("t3f7", 4'b0000);
      chk("t3f7_valid", 32'(effect_valid), 32'd0);

      // arbitration with two keys held
      frame("t4a", 4'b0101);
      chk("t4a_sel", 32'(effect_sel), 32'd0);
      for (int i = 0; i < 7; i++) frame("t4b", 4'b0101);
`ifdef OVERLAY_SCHED_FIXED_PRIO_EN
      chk("t4b_sel", 32'(effect_sel), 32'd0);
`else
      chk("t4b_sel", 32'(effect_sel), 32'd2);
`endif
      drain();

      // preemption by a competing key during hold
      frame("t5a", 4'b0010);
      chk("t5a_sel", 32'(effect_sel), 32'd1);
      frame("t5b", 4'b0010);
      frame("t5c", 4'b0010);
      frame("t5d", 4'b1010);
      chk("t5d_state", 32'(state_o), 32'd2);
      frame("t5e", 4'b1010);
      chk("t5e_state", 32'(state_o), 32'd3);
      for (int i = 0; i < 4; i++) frame("t5f", 4'b1010);
`ifndef OVERLAY_SCHED_FIXED_PRIO_EN
      chk("t5f_sel", 32'(effect_sel), 32'd3);
`endif
      drain();

      // request pulse between frames is ignored
      @(negedge clk);
      vsync = 1'b1;
      req = 4'b1111;
      repeat (10) @(negedge clk);
      req = '0;
      @(negedge clk);
      vsync = 1'b0;
      @(posedge clk);
      m_frame('0);
      @(negedge clk);
      check_all("t6pulse");

      // reset during fade-in
      frame("t6a", 4'b0001);
      frame("t6b", 4'b0001);
      chk("t6b_lvl", 32'(level), 32'd10);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      m_reset();
      check_all("t6rst");
      reset = 1'b0;

      // random requests
      for (int i = 0; i < 60; i++) begin
         rq = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom_range(1, 15));
         frame("rnd", rq);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
